// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit scheduler: frame width, idle line
// level and the sequencer state encoding.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_ARM   = S_ARM,
    ST_START = S_START,
    ST_DATA  = S_DATA,
    ST_STOP  = S_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester/scheduler bundle: byte requests and grants, baud-tick handshake
// and the serial line with its status flags.
interface uart_tx_sched_if #(
  parameter int NUM_REQ = 4
);
  import uart_pkg::*;

  logic [NUM_REQ-1:0]           req;
  logic [DATA_BITS*NUM_REQ-1:0] data;
  logic [NUM_REQ-1:0]           gnt;
  logic                         bps_en;
  logic                         bps_tick;
  logic                         txd;
  logic                         busy;
  logic                         done;

  modport master (
    output req, data, bps_tick,
    input  gnt, bps_en, txd, busy, done
  );

  modport slave (
    input  req, data, bps_tick,
    output gnt, bps_en, txd, busy, done
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from the requester after
// the last granted one and wraps around.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_ptr,
  output logic [NUM_REQ-1:0] win_onehot,
  output logic [IDX_W-1:0]   win_idx,
  output logic               win_valid
);

  // First requester found at offsets 1..NUM_REQ from the last grant wins.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    cand       = 0;
    cand_idx   = '0;
    win_onehot = '0;
    win_idx    = '0;
    win_valid  = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand     = (int'(last_ptr) + off) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!win_valid && req[cand_idx]) begin
        win_valid            = 1'b1;
        win_idx              = cand_idx;
        win_onehot[cand_idx] = 1'b1;
      end else begin
        win_valid = win_valid;
      end
    end
  end

endmodule

// File: rtl/uart_bps_gen.sv
// Baud-tick generator: one-cycle tick every BPS_PARA clocks while enabled;
// dropping the enable clears the divider so each frame starts in phase.
module uart_bps_gen #(
  parameter  int BPS_PARA = 8,
  localparam int CNT_W    = $clog2(BPS_PARA)
) (
  input  logic clk,
  input  logic RST,
  input  logic bps_en,
  output logic bps_tick
);

  logic [CNT_W-1:0] cnt_r;
  logic             tick_r;

  // Clock divider with registered tick output.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (!bps_en) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (cnt_r == CNT_W'(BPS_PARA - 1)) begin
      cnt_r  <= '0;
      tick_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_r + CNT_W'(1);
      tick_r <= 1'b0;
    end
  end

  assign bps_tick = tick_r;

endmodule

// File: rtl/uart_tx_sched_chk.sv
// Invariants of the scheduler outputs; evaluated only in simulation.
module uart_tx_sched_chk #(
  parameter int NUM_REQ = 4
) (
  input logic               clk,
  input logic               RST,
  input logic [NUM_REQ-1:0] gnt,
  input logic               bps_en,
  input logic               txd,
  input logic               busy,
  input logic               done
);

  a_gnt_onehot: assert property (@(posedge clk) disable iff (RST) $onehot0(gnt));
  a_gnt_busy:   assert property (@(posedge clk) disable iff (RST) (|gnt) |-> (busy && bps_en));
  a_done_idle:  assert property (@(posedge clk) disable iff (RST) done |-> (!busy && !bps_en));
  a_line_idle:  assert property (@(posedge clk) disable iff (RST) !bps_en |-> txd);

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that serializes one granted byte at a time as 8N1,
// LSB first, paced by an external baud-tick generator it enables.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input logic            clk,
  input logic            RST,
  uart_tx_sched_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  tx_state_e            state_r;
  logic [NUM_REQ-1:0]   gnt_r;
  logic                 bps_en_r;
  logic                 txd_r;
  logic                 busy_r;
  logic                 done_r;
  logic [DATA_BITS-1:0] shift_r;
  logic [CNT_W-1:0]     bit_cnt_r;
  logic [IDX_W-1:0]     gidx_r;
  logic [IDX_W-1:0]     ptr_r;

  logic [NUM_REQ-1:0]   win_onehot_s;
  logic [IDX_W-1:0]     win_idx_s;
  logic                 win_valid_s;
  logic                 tick_s;
  logic [DATA_BITS-1:0] req_byte_s [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
    assign req_byte_s[i] = bus.data[i*DATA_BITS +: DATA_BITS];
  end

  // A tick that lands while the generator is disabled is a stale pulse.
  assign tick_s = bus.bps_tick & bps_en_r;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req        (bus.req),
    .last_ptr   (ptr_r),
    .win_onehot (win_onehot_s),
    .win_idx    (win_idx_s),
    .win_valid  (win_valid_s)
  );

  // Frame sequencer: arbitrate in IDLE, then one line bit per baud tick.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_r   <= ST_IDLE;
      gnt_r     <= '0;
      bps_en_r  <= 1'b0;
      txd_r     <= IDLE_LEVEL;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      shift_r   <= '0;
      bit_cnt_r <= '0;
      gidx_r    <= '0;
      ptr_r     <= IDX_W'(NUM_REQ - 1);
    end else begin
      gnt_r  <= '0;
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          txd_r <= IDLE_LEVEL;
          if (win_valid_s) begin
            gnt_r    <= win_onehot_s;
            shift_r  <= req_byte_s[win_idx_s];
            gidx_r   <= win_idx_s;
            bps_en_r <= 1'b1;
            busy_r   <= 1'b1;
            state_r  <= ST_ARM;
          end else begin
            bps_en_r <= 1'b0;
            busy_r   <= 1'b0;
          end
        end
        ST_ARM: begin
          if (tick_s) begin
            txd_r   <= 1'b0;
            state_r <= ST_START;
          end
        end
        ST_START: begin
          if (tick_s) begin
            txd_r     <= shift_r[0];
            bit_cnt_r <= '0;
            state_r   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick_s) begin
            if (bit_cnt_r < LAST_BIT) begin
              shift_r   <= {1'b0, shift_r[DATA_BITS-1:1]};
              txd_r     <= shift_r[1];
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end else begin
              txd_r   <= IDLE_LEVEL;
              state_r <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (tick_s) begin
            done_r   <= 1'b1;
            bps_en_r <= 1'b0;
            busy_r   <= 1'b0;
            ptr_r    <= gidx_r;
            state_r  <= ST_IDLE;
          end
        end
        default: begin
          txd_r    <= IDLE_LEVEL;
          bps_en_r <= 1'b0;
          busy_r   <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt    = gnt_r;
  assign bus.bps_en = bps_en_r;
  assign bus.txd    = txd_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;

  uart_tx_sched_chk #(
    .NUM_REQ (NUM_REQ)
  ) u_chk (
    .clk    (clk),
    .RST    (RST),
    .gnt    (gnt_r),
    .bps_en (bps_en_r),
    .txd    (txd_r),
    .busy   (busy_r),
    .done   (done_r)
  );

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: scoreboard of expected grants and
// bytes, decoded from txd by a simple UART receiver model.
module tb_uart_tx_sched;
  import uart_pkg::*;

  localparam int NUM_REQ = 4;

  typedef struct {
    int         idx;
    logic [7:0] b;
  } exp_t;

  logic clk      = 1'b0;
  logic RST      = 1'b1;
  logic tb_tick  = 1'b0;
  logic inj_tick = 1'b0;
  logic use_gen  = 1'b0;
  logic gen_tick;
  int   tick_cnt = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  uart_tx_sched_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_sched #(.NUM_REQ(NUM_REQ)) dut (.clk(clk), .RST(RST), .bus(bus));

  uart_bps_gen #(.BPS_PARA(8)) u_gen (
    .clk(clk), .RST(RST), .bps_en(bus.bps_en), .bps_tick(gen_tick)
  );

  assign bus.bps_tick = use_gen ? gen_tick : (tb_tick | inj_tick);

  always #5 clk = ~clk;

  // Bench tick source: one pulse every 8 cycles, driven on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      tick_cnt++;
      tb_tick = (tick_cnt % 8 == 0);
    end
  end

  function automatic exp_t pop_exp();
    exp_t e;
    e.idx = -1;
    e.b   = 8'h00;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    return e;
  endfunction

  task automatic wait_gnt(output logic [NUM_REQ-1:0] g, output bit got);
    g   = '0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (bus.gnt !== '0) begin
        g   = bus.gnt;
        got = 1'b1;
      end
    end
  endtask

  // UART receiver model: find the start bit, record 80 cycles, decode.
  task automatic capture_frame(output logic [7:0] b, output bit wok, output bit got);
    logic s [80];
    b   = 8'h00;
    wok = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 80; i++) s[i] = 1'b1;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (bus.txd === 1'b0) got = 1'b1;
    end
    if (got) begin
      s[0] = bus.txd;
      for (int i = 1; i < 80; i++) begin
        @(negedge clk);
        s[i] = bus.txd;
      end
      for (int j = 0; j < 10; j++)
        for (int k = 1; k < 8; k++)
          if (s[8*j+k] !== s[8*j]) wok = 1'b0;
      if (s[72] !== 1'b1) wok = 1'b0;
      for (int j = 0; j < 8; j++) b[j] = s[8*(j+1)];
    end
  endtask

  task automatic test_reset();
    logic [7:0] obs;
    RST = 1'b1;
    bus.req  = '0;
    bus.data = '0;
    repeat (3) @(negedge clk);
    obs = {bus.txd, bus.bps_en, bus.gnt, bus.busy, bus.done};
    n_checks++;
    if (obs !== 8'b1_0_0000_0_0) begin
      n_fail++;
      $display("FAIL reset_outputs: got txd,en,gnt,busy,done=%b want 10000000", obs);
    end
    RST = 1'b0;
    repeat (2) @(negedge clk);
    obs = {bus.txd, bus.bps_en, bus.gnt, bus.busy, bus.done};
    n_checks++;
    if (obs !== 8'b1_0_0000_0_0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got %b want 10000000", obs);
    end
  endtask

  task automatic test_contention();
    logic [NUM_REQ-1:0] g;
    logic [NUM_REQ-1:0] want_g;
    logic [7:0]         b;
    logic [7:0]         bytes [4];
    bit                 got, fgot, wok;
    exp_t               e;
    bytes = '{8'h00, 8'h11, 8'h22, 8'h33};
    bus.data = {8'h33, 8'h22, 8'h11, 8'h00};
    for (int k = 0; k < 5; k++) exp_q.push_back('{idx: k % NUM_REQ, b: bytes[k % NUM_REQ]});
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(g, got);
      if (k == 4) bus.req = '0;
      e = pop_exp();
      want_g = NUM_REQ'(1) << e.idx;
      n_checks++;
      if (!got || g !== want_g) begin
        n_fail++;
        $display("FAIL contention_gnt[%0d]: got %b (seen %0d) want %b", k, g, got, want_g);
      end
      capture_frame(b, wok, fgot);
      n_checks++;
      if (!fgot || !wok || b !== e.b) begin
        n_fail++;
        $display("FAIL contention_byte[%0d]: got %h widths_ok %0d found %0d want %h", k, b, wok, fgot, e.b);
      end
      @(negedge clk);
      n_checks++;
      if (bus.done !== 1'b1 || bus.bps_en !== 1'b0) begin
        n_fail++;
        $display("FAIL contention_gap[%0d]: got done %b bps_en %b want 1 0", k, bus.done, bus.bps_en);
      end
    end
  endtask

  task automatic test_single();
    logic [NUM_REQ-1:0] g;
    logic [7:0]         b;
    bit                 got, fgot, wok;
    exp_t               e;
    bus.data[23:16] = 8'hA5;
    exp_q.push_back('{idx: 2, b: 8'hA5});
    bus.req = 4'b0100;
    wait_gnt(g, got);
    bus.req = '0;
    e = pop_exp();
    n_checks++;
    if (!got || g !== (NUM_REQ'(1) << e.idx)) begin
      n_fail++;
      $display("FAIL single_gnt: got %b (seen %0d) want 0100", g, got);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b1 || bus.bps_en !== 1'b1) begin
      n_fail++;
      $display("FAIL single_gnt_pulse: got gnt %b busy %b en %b want 0000 1 1", bus.gnt, bus.busy, bus.bps_en);
    end
    capture_frame(b, wok, fgot);
    n_checks++;
    if (!fgot || !wok || b !== e.b) begin
      n_fail++;
      $display("FAIL single_frame: got %h widths_ok %0d found %0d want %h", b, wok, fgot, e.b);
    end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.bps_en !== 1'b0 || bus.txd !== 1'b1) begin
      n_fail++;
      $display("FAIL single_done: got done %b busy %b en %b txd %b want 1 0 0 1", bus.done, bus.busy, bus.bps_en, bus.txd);
    end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_after: got done %b busy %b want 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_fairness();
    logic [NUM_REQ-1:0] g;
    logic [7:0]         b;
    bit                 got, fgot, wok;
    exp_t               e;
    bus.data[7:0]   = 8'h3C;
    bus.data[23:16] = 8'hE1;
    exp_q.push_back('{idx: 0, b: 8'h3C});
    exp_q.push_back('{idx: 2, b: 8'hE1});
    bus.req = 4'b0101;
    for (int k = 0; k < 2; k++) begin
      wait_gnt(g, got);
      bus.req = bus.req & ~g;
      e = pop_exp();
      n_checks++;
      if (!got || g !== (NUM_REQ'(1) << e.idx)) begin
        n_fail++;
        $display("FAIL fairness_gnt[%0d]: got %b (seen %0d) want idx %0d", k, g, got, e.idx);
      end
      capture_frame(b, wok, fgot);
      n_checks++;
      if (!fgot || !wok || b !== e.b) begin
        n_fail++;
        $display("FAIL fairness_byte[%0d]: got %h widths_ok %0d want %h", k, b, wok, e.b);
      end
      @(negedge clk);
    end
    bus.req = '0;
  endtask

  task automatic test_reset_mid();
    logic [NUM_REQ-1:0] g;
    logic [7:0]         b;
    logic [7:0]         obs;
    bit                 got, fgot, wok;
    exp_t               e;
    bus.data[31:24] = 8'hC3;
    bus.req = 4'b1000;
    wait_gnt(g, got);
    bus.req = '0;
    n_checks++;
    if (!got || g !== 4'b1000) begin
      n_fail++;
      $display("FAIL resetmid_first_gnt: got %b want 1000", g);
    end
    fgot = 1'b0;
    for (int i = 0; i < 40 && !fgot; i++) begin
      @(negedge clk);
      if (bus.txd === 1'b0) fgot = 1'b1;
    end
    repeat (36) @(negedge clk);
    RST = 1'b1;
    #1;
    obs = {bus.txd, bus.bps_en, bus.gnt, bus.busy, bus.done};
    n_checks++;
    if (!fgot || obs !== 8'b1_0_0000_0_0) begin
      n_fail++;
      $display("FAIL resetmid_outputs: got %b (start seen %0d) want 10000000", obs, fgot);
    end
    bus.data[15:8] = 8'h5D;
    exp_q.push_back('{idx: 1, b: 8'h5D});
    bus.req = 4'b0010;
    repeat (2) @(negedge clk);
    RST = 1'b0;
    wait_gnt(g, got);
    bus.req = '0;
    e = pop_exp();
    n_checks++;
    if (!got || g !== (NUM_REQ'(1) << e.idx)) begin
      n_fail++;
      $display("FAIL resetmid_gnt: got %b want 0010", g);
    end
    capture_frame(b, wok, fgot);
    n_checks++;
    if (!fgot || !wok || b !== e.b) begin
      n_fail++;
      $display("FAIL resetmid_frame: got %h widths_ok %0d want %h", b, wok, e.b);
    end
    @(negedge clk);
  endtask

  task automatic test_withdraw();
    logic [NUM_REQ-1:0] g;
    logic [7:0]         b;
    bit                 got, fgot, wok;
    int                 n_g, n_bad;
    exp_t               e;
    bus.data[7:0] = 8'h96;
    exp_q.push_back('{idx: 0, b: 8'h96});
    bus.req = 4'b0001;
    wait_gnt(g, got);
    bus.req = '0;
    e = pop_exp();
    n_checks++;
    if (!got || g !== (NUM_REQ'(1) << e.idx)) begin
      n_fail++;
      $display("FAIL withdraw_gnt: got %b want 0001", g);
    end
    #2;
    bus.data[31:24] = 8'hFF;
    bus.req = 4'b1000;
    @(posedge clk);
    #1;
    bus.req = '0;
    capture_frame(b, wok, fgot);
    n_checks++;
    if (!fgot || !wok || b !== e.b) begin
      n_fail++;
      $display("FAIL withdraw_frame: got %h widths_ok %0d want %h", b, wok, e.b);
    end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL withdraw_done: got %b want 1", bus.done);
    end
    inj_tick = 1'b1;
    @(negedge clk);
    inj_tick = 1'b0;
    n_g   = 0;
    n_bad = 0;
    for (int i = 0; i < 24; i++) begin
      if (bus.gnt !== '0) n_g++;
      if (bus.txd !== 1'b1 || bus.bps_en !== 1'b0 || bus.busy !== 1'b0) n_bad++;
      @(negedge clk);
    end
    n_checks++;
    if (n_g != 0) begin
      n_fail++;
      $display("FAIL withdraw_no_gnt: got %0d grant cycles want 0", n_g);
    end
    n_checks++;
    if (n_bad != 0) begin
      n_fail++;
      $display("FAIL late_tick_idle: got %0d non-idle cycles want 0", n_bad);
    end
  endtask

  task automatic test_integration();
    logic [NUM_REQ-1:0] g;
    logic [7:0]         b;
    bit                 got, fgot, wok, dgot;
    exp_t               e;
    use_gen = 1'b1;
    bus.data[23:16] = 8'h5A;
    exp_q.push_back('{idx: 2, b: 8'h5A});
    bus.req = 4'b0100;
    wait_gnt(g, got);
    bus.req = '0;
    e = pop_exp();
    n_checks++;
    if (!got || g !== (NUM_REQ'(1) << e.idx)) begin
      n_fail++;
      $display("FAIL integ_gnt: got %b want 0100", g);
    end
    capture_frame(b, wok, fgot);
    n_checks++;
    if (!fgot || !wok || b !== e.b) begin
      n_fail++;
      $display("FAIL integ_frame: got %h widths_ok %0d found %0d want %h", b, wok, fgot, e.b);
    end
    dgot = 1'b0;
    for (int i = 0; i < 20 && !dgot; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dgot = 1'b1;
    end
    n_checks++;
    if (!dgot) begin
      n_fail++;
      $display("FAIL integ_done: got no done pulse want one");
    end
    use_gen = 1'b0;
  endtask

  initial begin
    bus.req  = '0;
    bus.data = '0;
    test_reset();
    test_contention();
    test_single();
    test_fairness();
    test_reset_mid();
    test_withdraw();
    test_integration();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d left want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
